// File: rtl/rs_alu_pkg.sv
// Shared types, opcode encoding and CDB snoop helper for the ALU reservation station.
package rs_alu_pkg;
    localparam int ROBBW       = 4;
    localparam int RS_SIZE_DEF = 16;
    localparam int RSBW_DEF    = 4;

    typedef enum logic [5:0] {
        OP_NOP = 6'd0, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND
    } alu_op_e;

    typedef struct packed {
        logic             busy;
        logic [5:0]       code;
        logic [31:0]      pc;
        logic [31:0]      v1;
        logic [ROBBW-1:0] q1;
        logic             q1_busy;
        logic [31:0]      v2;
        logic [ROBBW-1:0] q2;
        logic             q2_busy;
        logic [31:0]      a;
        logic [ROBBW-1:0] rob_id;
    } rs_entry_t;

    typedef struct packed {
        logic [5:0]       code;
        logic [31:0]      pc;
        logic [31:0]      v1;
        logic [31:0]      v2;
        logic [31:0]      a;
        logic [ROBBW-1:0] rob_id;
    } rs_issue_t;

    typedef struct packed {
        logic        pend;
        logic [31:0] val;
    } opnd_t;

    // A pending operand captures the first CDB carrying its producer tag; ALU wins a tie.
    function automatic opnd_t snoop(
        input logic pend, input logic [31:0] val, input logic [ROBBW-1:0] q,
        input logic af, input logic [ROBBW-1:0] aid, input logic [31:0] av,
        input logic lf, input logic [ROBBW-1:0] lid, input logic [31:0] lv);
        opnd_t r;
        r.pend = pend;
        r.val  = val;
        if (pend && af && (aid == q)) begin
            r.pend = 1'b0;
            r.val  = av;
        end else if (pend && lf && (lid == q)) begin
            r.pend = 1'b0;
            r.val  = lv;
        end
        return r;
    endfunction
endpackage

// File: rtl/rs_alu_if.sv
// Dispatch, CDB snoop and issue bundle between dispatcher, CDBs, rs_alu and alu.
interface rs_alu_if;
    import rs_alu_pkg::*;

    logic             dsp_flag;
    logic [5:0]       dsp_code;
    logic [31:0]      dsp_pc;
    logic [31:0]      dsp_V1;
    logic [ROBBW-1:0] dsp_Q1;
    logic             dsp_Q1_busy;
    logic [31:0]      dsp_V2;
    logic [ROBBW-1:0] dsp_Q2;
    logic             dsp_Q2_busy;
    logic [31:0]      dsp_A;
    logic [ROBBW-1:0] dsp_rob_id;
    logic             rs_full;

    logic             alu_cdb_flag;
    logic [ROBBW-1:0] alu_cdb_rob_id;
    logic [31:0]      alu_cdb_val;
    logic             lsb_cdb_flag;
    logic [ROBBW-1:0] lsb_cdb_rob_id;
    logic [31:0]      lsb_cdb_val;

    logic             ex_flag;
    logic [31:0]      ex_V1;
    logic [31:0]      ex_V2;
    logic [31:0]      ex_A;
    logic [31:0]      ex_pc;
    logic [5:0]       ex_code;
    logic [ROBBW-1:0] ex_rob_id;

    modport master (
        output dsp_flag, dsp_code, dsp_pc, dsp_V1, dsp_Q1, dsp_Q1_busy,
               dsp_V2, dsp_Q2, dsp_Q2_busy, dsp_A, dsp_rob_id,
               alu_cdb_flag, alu_cdb_rob_id, alu_cdb_val,
               lsb_cdb_flag, lsb_cdb_rob_id, lsb_cdb_val,
        input  rs_full, ex_flag, ex_V1, ex_V2, ex_A, ex_pc, ex_code, ex_rob_id
    );

    modport slave (
        input  dsp_flag, dsp_code, dsp_pc, dsp_V1, dsp_Q1, dsp_Q1_busy,
               dsp_V2, dsp_Q2, dsp_Q2_busy, dsp_A, dsp_rob_id,
               alu_cdb_flag, alu_cdb_rob_id, alu_cdb_val,
               lsb_cdb_flag, lsb_cdb_rob_id, lsb_cdb_val,
        output rs_full, ex_flag, ex_V1, ex_V2, ex_A, ex_pc, ex_code, ex_rob_id
    );
endinterface

// File: rtl/rs_select.sv
// Free-slot finder and issue picker; lowest-index ready entry, or oldest ready entry
// when RS_AGE_SELECT_EN is defined.
module rs_select
    import rs_alu_pkg::*;
#(
    parameter int RS_SIZE = RS_SIZE_DEF,
    parameter int RSBW    = RSBW_DEF
) (
    input  logic [RS_SIZE-1:0]              busy_i,
    input  logic [RS_SIZE-1:0]              ready_i,
`ifdef RS_AGE_SELECT_EN
    input  logic [RS_SIZE-1:0][RS_SIZE-1:0] old_i,
`endif
    output logic [RSBW-1:0]                 free_idx_o,
    output logic                            free_found_o,
    output logic [RSBW-1:0]                 issue_idx_o,
    output logic                            issue_found_o
);
    logic [RS_SIZE-1:0] cand;

    always_comb begin
        cand = ready_i;
`ifdef RS_AGE_SELECT_EN
        // old_i[j][i] means j was dispatched before i; any older ready entry vetoes i.
        for (int i = 0; i < RS_SIZE; i++) begin
            for (int j = 0; j < RS_SIZE; j++) begin
                if (ready_i[j] && old_i[j][i]) cand[i] = 1'b0;
            end
        end
`endif
    end

    always_comb begin
        free_idx_o    = '0;
        free_found_o  = 1'b0;
        issue_idx_o   = '0;
        issue_found_o = 1'b0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy_i[i]) begin
                free_found_o = 1'b1;
                free_idx_o   = RSBW'(i);
            end
            if (cand[i]) begin
                issue_found_o = 1'b1;
                issue_idx_o   = RSBW'(i);
            end
        end
    end
endmodule

// File: rtl/rs_alu.sv
// ALU reservation station: holds dispatched ops, snoops both CDBs, issues one ready op
// per cycle on registered ex_* outputs. Optional oldest-first issue: RS_AGE_SELECT_EN.
module rs_alu
    import rs_alu_pkg::*;
#(
    parameter int RS_SIZE = RS_SIZE_DEF,
    parameter int RSBW    = RSBW_DEF
) (
    input  logic     clk_in,
    input  logic     rst_in,
    input  logic     rdy_in,
    input  logic     clear,
    rs_alu_if.slave  io
);
    rs_entry_t [RS_SIZE-1:0] ent_q, ent_d;
    rs_issue_t               ex_q, ex_d;
    logic                    ex_flag_q, ex_flag_d;

    logic [RS_SIZE-1:0] busy, ready;
    opnd_t [RS_SIZE-1:0] wk1, wk2;
    opnd_t               nd1, nd2;
    logic [RSBW-1:0]     free_idx, issue_idx;
    logic                free_found, issue_found;
    logic [RSBW:0]       occ;

    for (genvar g = 0; g < RS_SIZE; g++) begin : g_ent
        assign busy[g]  = ent_q[g].busy;
        assign ready[g] = ent_q[g].busy & ~ent_q[g].q1_busy & ~ent_q[g].q2_busy;
        assign wk1[g]   = snoop(ent_q[g].q1_busy, ent_q[g].v1, ent_q[g].q1,
                                io.alu_cdb_flag, io.alu_cdb_rob_id, io.alu_cdb_val,
                                io.lsb_cdb_flag, io.lsb_cdb_rob_id, io.lsb_cdb_val);
        assign wk2[g]   = snoop(ent_q[g].q2_busy, ent_q[g].v2, ent_q[g].q2,
                                io.alu_cdb_flag, io.alu_cdb_rob_id, io.alu_cdb_val,
                                io.lsb_cdb_flag, io.lsb_cdb_rob_id, io.lsb_cdb_val);
    end

    // Same-cycle forwarding for the instruction being dispatched.
    assign nd1 = snoop(io.dsp_Q1_busy, io.dsp_V1, io.dsp_Q1,
                       io.alu_cdb_flag, io.alu_cdb_rob_id, io.alu_cdb_val,
                       io.lsb_cdb_flag, io.lsb_cdb_rob_id, io.lsb_cdb_val);
    assign nd2 = snoop(io.dsp_Q2_busy, io.dsp_V2, io.dsp_Q2,
                       io.alu_cdb_flag, io.alu_cdb_rob_id, io.alu_cdb_val,
                       io.lsb_cdb_flag, io.lsb_cdb_rob_id, io.lsb_cdb_val);

`ifdef RS_AGE_SELECT_EN
    logic [RS_SIZE-1:0][RS_SIZE-1:0] old_q, old_d;

    always_comb begin
        old_d = old_q;
        if (!clear && io.dsp_flag && free_found) begin
            for (int j = 0; j < RS_SIZE; j++) old_d[j][free_idx] = busy[j];
            old_d[free_idx] = '0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)     old_q <= '0;
        else if (rdy_in) old_q <= old_d;
    end
`endif

    rs_select #(.RS_SIZE(RS_SIZE), .RSBW(RSBW)) u_sel (
        .busy_i        (busy),
        .ready_i       (ready),
`ifdef RS_AGE_SELECT_EN
        .old_i         (old_q),
`endif
        .free_idx_o    (free_idx),
        .free_found_o  (free_found),
        .issue_idx_o   (issue_idx),
        .issue_found_o (issue_found)
    );

    always_comb begin
        occ = '0;
        for (int i = 0; i < RS_SIZE; i++) occ = occ + (RSBW+1)'(busy[i]);
    end

    // One slot of slack: a dispatch may already be in flight when full is seen.
    assign io.rs_full = (occ >= (RSBW+1)'(RS_SIZE - 1));

    always_comb begin
        ent_d     = ent_q;
        ex_d      = ex_q;
        ex_flag_d = 1'b0;
        if (clear) begin
            for (int i = 0; i < RS_SIZE; i++) ent_d[i].busy = 1'b0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (ent_q[i].busy) begin
                    ent_d[i].q1_busy = wk1[i].pend;
                    ent_d[i].v1      = wk1[i].val;
                    ent_d[i].q2_busy = wk2[i].pend;
                    ent_d[i].v2      = wk2[i].val;
                end
            end
            if (issue_found) begin
                ex_flag_d   = 1'b1;
                ex_d.code   = ent_q[issue_idx].code;
                ex_d.pc     = ent_q[issue_idx].pc;
                ex_d.v1     = ent_q[issue_idx].v1;
                ex_d.v2     = ent_q[issue_idx].v2;
                ex_d.a      = ent_q[issue_idx].a;
                ex_d.rob_id = ent_q[issue_idx].rob_id;
                ent_d[issue_idx].busy = 1'b0;
            end
            // free_idx comes from registered busy bits, so it never aliases issue_idx.
            if (io.dsp_flag && free_found) begin
                ent_d[free_idx].busy    = 1'b1;
                ent_d[free_idx].code    = io.dsp_code;
                ent_d[free_idx].pc      = io.dsp_pc;
                ent_d[free_idx].v1      = nd1.val;
                ent_d[free_idx].q1      = io.dsp_Q1;
                ent_d[free_idx].q1_busy = nd1.pend;
                ent_d[free_idx].v2      = nd2.val;
                ent_d[free_idx].q2      = io.dsp_Q2;
                ent_d[free_idx].q2_busy = nd2.pend;
                ent_d[free_idx].a       = io.dsp_A;
                ent_d[free_idx].rob_id  = io.dsp_rob_id;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            ent_q     <= '0;
            ex_q      <= '0;
            ex_flag_q <= 1'b0;
        end else if (rdy_in) begin
            ent_q     <= ent_d;
            ex_q      <= ex_d;
            ex_flag_q <= ex_flag_d;
        end else begin
            ex_flag_q <= 1'b0;
        end
    end

    assign io.ex_flag   = ex_flag_q;
    assign io.ex_code   = ex_q.code;
    assign io.ex_pc     = ex_q.pc;
    assign io.ex_V1     = ex_q.v1;
    assign io.ex_V2     = ex_q.v2;
    assign io.ex_A      = ex_q.a;
    assign io.ex_rob_id = ex_q.rob_id;
endmodule

// File: tb/tb_rs_alu.sv
// Directed bench for rs_alu: vector table for dispatch/forwarding plus wake-up, full,
// clear, rdy, issue-policy and async-reset sequences.
module tb_rs_alu;
    import rs_alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rdy = 1'b1;
    logic clr = 1'b0;
    int   nchk = 0;
    int   nerr = 0;

    rs_alu_if bus();

    rs_alu #(.RS_SIZE(16), .RSBW(4)) dut (
        .clk_in (clk),
        .rst_in (rst_n),
        .rdy_in (rdy),
        .clear  (clr),
        .io     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  code;
        logic [31:0] pc;
        logic [31:0] v1;
        logic [3:0]  q1;
        logic        q1b;
        logic [31:0] v2;
        logic [3:0]  q2;
        logic        q2b;
        logic [31:0] a;
        logic [3:0]  rob;
        logic        af;
        logic [3:0]  aid;
        logic [31:0] av;
        logic        lf;
        logic [3:0]  lid;
        logic [31:0] lv;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.dsp_flag = 1'b0; bus.dsp_code = '0; bus.dsp_pc = '0;
        bus.dsp_V1 = '0; bus.dsp_Q1 = '0; bus.dsp_Q1_busy = 1'b0;
        bus.dsp_V2 = '0; bus.dsp_Q2 = '0; bus.dsp_Q2_busy = 1'b0;
        bus.dsp_A = '0; bus.dsp_rob_id = '0;
        bus.alu_cdb_flag = 1'b0; bus.alu_cdb_rob_id = '0; bus.alu_cdb_val = '0;
        bus.lsb_cdb_flag = 1'b0; bus.lsb_cdb_rob_id = '0; bus.lsb_cdb_val = '0;
    endtask

    task automatic put(input vec_t v);
        bus.dsp_flag = 1'b1; bus.dsp_code = v.code; bus.dsp_pc = v.pc;
        bus.dsp_V1 = v.v1; bus.dsp_Q1 = v.q1; bus.dsp_Q1_busy = v.q1b;
        bus.dsp_V2 = v.v2; bus.dsp_Q2 = v.q2; bus.dsp_Q2_busy = v.q2b;
        bus.dsp_A = v.a; bus.dsp_rob_id = v.rob;
        bus.alu_cdb_flag = v.af; bus.alu_cdb_rob_id = v.aid; bus.alu_cdb_val = v.av;
        bus.lsb_cdb_flag = v.lf; bus.lsb_cdb_rob_id = v.lid; bus.lsb_cdb_val = v.lv;
    endtask

    // ADD blocked on Q1, V2 carries the rob id for traceability.
    task automatic dsp_blk(input logic [3:0] q1, input logic [3:0] rob);
        idle();
        bus.dsp_flag = 1'b1; bus.dsp_code = OP_ADD;
        bus.dsp_Q1 = q1; bus.dsp_Q1_busy = 1'b1;
        bus.dsp_V2 = 32'(rob); bus.dsp_rob_id = rob;
    endtask

    task automatic cdb(input logic af, input logic [3:0] aid, input logic [31:0] av,
                       input logic lf, input logic [3:0] lid, input logic [31:0] lv);
        idle();
        bus.alu_cdb_flag = af; bus.alu_cdb_rob_id = aid; bus.alu_cdb_val = av;
        bus.lsb_cdb_flag = lf; bus.lsb_cdb_rob_id = lid; bus.lsb_cdb_val = lv;
    endtask

    initial begin
        logic [3:0]  first_rob, second_rob;
        logic [31:0] first_v1, second_v1;

        tbl[0] = '{OP_ADD, 32'h1000, 32'd5, 4'd0, 1'b0, 32'd7, 4'd0, 1'b0, 32'd0, 4'd3,
                   1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd5, 32'd7};
        tbl[1] = '{OP_ADD, 32'h1004, 32'd0, 4'd4, 1'b1, 32'h20, 4'd0, 1'b0, 32'd0, 4'd7,
                   1'b1, 4'd4, 32'd9, 1'b0, 4'd0, 32'd0, 32'd9, 32'h20};
        tbl[2] = '{OP_SUB, 32'h1008, 32'd1, 4'd0, 1'b0, 32'd0, 4'd6, 1'b1, 32'd0, 4'd8,
                   1'b0, 4'd0, 32'd0, 1'b1, 4'd6, 32'hABCD, 32'd1, 32'hABCD};
        tbl[3] = '{OP_BEQ, 32'h100C, 32'd0, 4'd1, 1'b1, 32'd0, 4'd2, 1'b1, 32'h40, 4'd9,
                   1'b1, 4'd1, 32'h11, 1'b1, 4'd2, 32'h22, 32'h11, 32'h22};
        // Q2 tag matches the CDB but Q2 is not pending: its dispatched value must survive.
        tbl[4] = '{OP_ADD, 32'h1010, 32'd0, 4'd5, 1'b1, 32'h77, 4'd5, 1'b0, 32'd0, 4'd10,
                   1'b1, 4'd5, 32'h55, 1'b0, 4'd0, 32'd0, 32'h55, 32'h77};

        idle();
        repeat (3) @(posedge clk);
        #1;
        chk("reset ex_flag", 32'(bus.ex_flag), 32'd0);
        chk("reset rs_full", 32'(bus.rs_full), 32'd0);
        chk("reset ex_V1", bus.ex_V1, 32'd0);
        chk("reset ex_code", 32'(bus.ex_code), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            put(tbl[i]);
            cyc();
            idle();
            chk($sformatf("vec%0d flag_early", i), 32'(bus.ex_flag), 32'd0);
            cyc();
            chk($sformatf("vec%0d ex_flag", i), 32'(bus.ex_flag), 32'd1);
            chk($sformatf("vec%0d ex_code", i), 32'(bus.ex_code), 32'(tbl[i].code));
            chk($sformatf("vec%0d ex_pc", i), bus.ex_pc, tbl[i].pc);
            chk($sformatf("vec%0d ex_V1", i), bus.ex_V1, tbl[i].e1);
            chk($sformatf("vec%0d ex_V2", i), bus.ex_V2, tbl[i].e2);
            chk($sformatf("vec%0d ex_A", i), bus.ex_A, tbl[i].a);
            chk($sformatf("vec%0d ex_rob_id", i), 32'(bus.ex_rob_id), 32'(tbl[i].rob));
            cyc();
            chk($sformatf("vec%0d flag_drop", i), 32'(bus.ex_flag), 32'd0);
        end

        // ADDI waiting on rob 2, woken by the LSB CDB three cycles later.
        put('{OP_ADDI, 32'h2000, 32'd0, 4'd2, 1'b1, 32'd0, 4'd0, 1'b0, 32'd1, 4'd6,
              1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0, 32'd0});
        cyc();
        idle();
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("addi blocked", 32'(bus.ex_flag), 32'd0);
        end
        cdb(1'b0, 4'd0, 32'd0, 1'b1, 4'd2, 32'h10);
        cyc();
        idle();
        chk("addi wake_edge", 32'(bus.ex_flag), 32'd0);
        cyc();
        chk("addi ex_flag", 32'(bus.ex_flag), 32'd1);
        chk("addi ex_V1", bus.ex_V1, 32'h10);
        chk("addi ex_A", bus.ex_A, 32'd1);
        chk("addi ex_code", 32'(bus.ex_code), 32'(OP_ADDI));
        chk("addi ex_rob_id", 32'(bus.ex_rob_id), 32'd6);

        // rdy_in low holds a ready entry in place.
        put(tbl[0]);
        cyc();
        idle();
        rdy = 1'b0;
        cyc();
        chk("rdy_low flag0", 32'(bus.ex_flag), 32'd0);
        cyc();
        chk("rdy_low flag1", 32'(bus.ex_flag), 32'd0);
        rdy = 1'b1;
        cyc();
        chk("rdy_high ex_flag", 32'(bus.ex_flag), 32'd1);
        chk("rdy_high ex_rob_id", 32'(bus.ex_rob_id), 32'd3);
        cyc();

        // Fill 15 entries, each blocked on its own tag.
        for (int i = 0; i < 15; i++) begin
            dsp_blk(4'(i), 4'(i));
            cyc();
            if (i == 13) chk("full at 14", 32'(bus.rs_full), 32'd0);
        end
        idle();
        chk("full at 15", 32'(bus.rs_full), 32'd1);
        cdb(1'b1, 4'd3, 32'h33, 1'b0, 4'd0, 32'd0);
        cyc();
        idle();
        chk("full wake_edge", 32'(bus.rs_full), 32'd1);
        chk("full wake_flag", 32'(bus.ex_flag), 32'd0);
        cyc();
        chk("full issue flag", 32'(bus.ex_flag), 32'd1);
        chk("full issue rob", 32'(bus.ex_rob_id), 32'd3);
        chk("full issue V1", bus.ex_V1, 32'h33);
        chk("full drop", 32'(bus.rs_full), 32'd0);
        dsp_blk(4'd15, 4'd15);
        cyc();
        idle();
        chk("full again", 32'(bus.rs_full), 32'd1);

        // clear wins over a same-cycle ready dispatch; later CDBs find nothing.
        put(tbl[0]);
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        idle();
        chk("clear ex_flag", 32'(bus.ex_flag), 32'd0);
        chk("clear rs_full", 32'(bus.rs_full), 32'd0);
        cyc();
        chk("clear no_dsp", 32'(bus.ex_flag), 32'd0);
        cdb(1'b1, 4'd5, 32'd1, 1'b1, 4'd15, 32'd2);
        cyc();
        idle();
        cyc();
        chk("clear no_wake", 32'(bus.ex_flag), 32'd0);

        // Slots 0..5 blocked on tags 8..13; free slot 0, refill it, then wake 0 and 5 together.
        for (int i = 0; i < 6; i++) begin
            dsp_blk(4'(8 + i), 4'(i));
            cyc();
        end
        cdb(1'b1, 4'd8, 32'd1, 1'b0, 4'd0, 32'd0);
        cyc();
        idle();
        cyc();
        chk("age slot0 rob", 32'(bus.ex_rob_id), 32'd0);
        dsp_blk(4'd14, 4'd15);
        cyc();
        cdb(1'b1, 4'd14, 32'hE, 1'b1, 4'd13, 32'hD);
        cyc();
        idle();
`ifdef RS_AGE_SELECT_EN
        first_rob = 4'd5;  first_v1 = 32'hD;
        second_rob = 4'd15; second_v1 = 32'hE;
`else
        first_rob = 4'd15; first_v1 = 32'hE;
        second_rob = 4'd5;  second_v1 = 32'hD;
`endif
        cyc();
        chk("policy first flag", 32'(bus.ex_flag), 32'd1);
        chk("policy first rob", 32'(bus.ex_rob_id), 32'(first_rob));
        chk("policy first V1", bus.ex_V1, first_v1);
        cyc();
        chk("policy second flag", 32'(bus.ex_flag), 32'd1);
        chk("policy second rob", 32'(bus.ex_rob_id), 32'(second_rob));
        chk("policy second V1", bus.ex_V1, second_v1);

        // Slots 1..4 still busy; add 11 more, then reset asynchronously mid-cycle.
        for (int i = 0; i < 11; i++) begin
            dsp_blk(4'd15, 4'd15);
            cyc();
        end
        idle();
        chk("pre_reset full", 32'(bus.rs_full), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rs_full", 32'(bus.rs_full), 32'd0);
        chk("async ex_flag", 32'(bus.ex_flag), 32'd0);
        chk("async ex_rob_id", 32'(bus.ex_rob_id), 32'd0);
        #1;
        rst_n = 1'b1;
        cdb(1'b1, 4'd15, 32'd3, 1'b1, 4'd9, 32'd4);
        cyc();
        idle();
        cyc();
        chk("post_reset no_issue", 32'(bus.ex_flag), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
